// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes, functs, ALU codes.
// No logic, no latency, no backpressure.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BEQ,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // alu_op: what the FSM asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps FSM alu_op plus R-type funct to the 3-bit ALU operation; purely combinational.
// No backpressure; unknown functs fall back to add.
module alu_decoder
    import mips_pkg::*;
#(
    parameter int OP_WIDTH = 6
) (
    input  logic [1:0]          alu_op,
    input  logic [OP_WIDTH-1:0] funct,
    output logic [2:0]          alu_cntrl
);

    always_comb begin
        alu_cntrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_cntrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    OP_WIDTH'(FN_ADD): alu_cntrl = ALU_ADD;
                    OP_WIDTH'(FN_SUB): alu_cntrl = ALU_SUB;
                    OP_WIDTH'(FN_AND): alu_cntrl = ALU_AND;
                    OP_WIDTH'(FN_OR):  alu_cntrl = ALU_OR;
                    OP_WIDTH'(FN_SLT): alu_cntrl = ALU_SLT;
                    default:           alu_cntrl = ALU_ADD;
                endcase
            end
            default: alu_cntrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (Moore); instructions retire in 2..5 cycles, strobes track state.
// No backpressure; pc_en is the only output combinational on an input (zero_f).
module mc_controller
    import mips_pkg::*;
#(
    parameter int OP_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic [OP_WIDTH-1:0] funct,
    input  logic                zero_f,
    output logic                iord,
    output logic                ir_write,
    output logic                mem_write,
    output logic                we_regf,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_cntrl,
    output logic [1:0]          pc_src,
    output logic                pc_en,
    output logic                instr_done,
    output logic                illegal_op
);

    state_e state_q, state_d;

    logic op_lw, op_sw, op_rtype, op_beq, op_addi, op_j, op_known;
    logic ir_write_s, mem_write_s, we_regf_s, done_s, pc_write, branch;
    logic [1:0] alu_op;

    assign op_lw    = (opcode == OP_WIDTH'(OP_LW));
    assign op_sw    = (opcode == OP_WIDTH'(OP_SW));
    assign op_rtype = (opcode == OP_WIDTH'(OP_RTYPE));
    assign op_beq   = (opcode == OP_WIDTH'(OP_BEQ));
    assign op_addi  = (opcode == OP_WIDTH'(OP_ADDI));
    assign op_j     = (opcode == OP_WIDTH'(OP_J));
    assign op_known = op_lw | op_sw | op_rtype | op_beq | op_addi | op_j;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (op_lw || op_sw)  state_d = S_MEMADR;
                else if (op_rtype)   state_d = S_EXECUTE;
                else if (op_beq)     state_d = S_BEQ;
                else if (op_addi)    state_d = S_ADDIEX;
                else if (op_j)       state_d = S_JUMP;
                else                 state_d = S_FETCH;
            end
            S_MEMADR:  state_d = op_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord        = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        we_regf_s   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = ALUOP_ADD;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                done_s    = ~op_known;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                we_regf_s  = 1'b1;
                mem_to_reg = 1'b1;
                done_s     = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                we_regf_s = 1'b1;
                reg_dst   = 1'b1;
                done_s    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
                done_s    = 1'b1;
            end
            S_ADDIWB: begin
                we_regf_s = 1'b1;
                done_s    = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                done_s   = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder #(
        .OP_WIDTH (OP_WIDTH)
    ) u_alu_decoder (
        .alu_op    (alu_op),
        .funct     (funct),
        .alu_cntrl (alu_cntrl)
    );

    // Reset forces FETCH, but the strobes must also drop while reset is still held.
    assign ir_write   = ir_write_s & rst;
    assign mem_write  = mem_write_s & rst;
    assign we_regf    = we_regf_s & rst;
    assign instr_done = done_s & rst;
    assign pc_en      = (pc_write | (branch & zero_f)) & rst;
    assign illegal_op = (state_q == S_DECODE) & ~op_known & rst;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 6, meaning width of the opcode and funct fields.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opcode  input  OP_WIDTH  instr[31:26] from the instruction register.
REQ-005 SHALL have port funct  input  OP_WIDTH  instr[5:0] from the instruction register.
REQ-006 SHALL have port zero_f  input  1  ALU zero flag from the datapath.
REQ-007 SHALL have port iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 SHALL have port ir_write  output  1  instruction register load enable.
REQ-009 SHALL have port mem_write  output  1  data memory write enable.
REQ-010 SHALL have port we_regf  output  1  register file write enable.
REQ-011 SHALL have port reg_dst  output  1  destination select: 0 = instr[20:16], 1 = instr[15:11].
REQ-012 SHALL have port mem_to_reg  output  1  write-back select: 0 = ALU result register, 1 = memory data register.
REQ-013 SHALL have port alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-014 SHALL have port alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-015 SHALL have port alu_cntrl  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-016 SHALL have port pc_src  output  2  next-PC select: 00 = ALU, 01 = ALU result register, 10 = jump address.
REQ-017 SHALL have port pc_en  output  1  PC load enable.
REQ-018 SHALL have port instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-019 SHALL have port illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-020 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP.
REQ-021 SHALL use these transitions: FETCH->DECODE; DECODE->MEMADR for lw (100011) or sw (101011); DECODE->EXECUTE for R-type (000000); DECODE->BEQ for 000100; DECODE->ADDIEX for 001000; DECODE->JUMP for 000010; DECODE->FETCH for any other opcode.
REQ-022 SHALL use these transitions: MEMADR->MEMRD for lw and MEMADR->MEMWR for sw; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, ADDIWB, BEQ and JUMP all ->FETCH.
REQ-023 SHALL drive the following outputs per state; any output not listed is 0, and alu_cntrl is 010 unless listed.
- FETCH: ir_write=1, pc_write=1, alu_src_b=01, add.
- DECODE: alu_src_b=11, add.
- MEMADR: alu_src_a=1, alu_src_b=10, add.
- MEMRD: iord=1.
- MEMWB: we_regf=1, mem_to_reg=1.
- MEMWR: iord=1, mem_write=1.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_cntrl from funct.
- ALUWB: we_regf=1, reg_dst=1.
- BEQ: alu_src_a=1, sub, pc_src=01, branch=1.
- ADDIEX: alu_src_a=1, alu_src_b=10, add.
- ADDIWB: we_regf=1.
- JUMP: pc_src=10, pc_write=1.
REQ-024 SHALL compute pc_en = pc_write OR (branch AND zero_f); this is the only output that is combinational on an input (zero_f).
REQ-025 SHALL decode funct as: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct SHALL produce 010.
REQ-026 SHALL assert instr_done in MEMWB, MEMWR, ALUWB, ADDIWB, BEQ and JUMP, and in DECODE when the opcode is unsupported.
REQ-027 SHALL assert illegal_op only in DECODE with an unsupported opcode; such an instruction retires as a NOP in 2 cycles.
REQ-028 SHALL give these instruction latencies in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-029 SHALL sample opcode and funct only in DECODE, MEMADR and EXECUTE; the values are held stable by the instruction register.

Reset
REQ-030 SHALL force the state to FETCH asynchronously while rst=0.
REQ-031 SHALL, while rst=0, force ir_write, pc_en, mem_write, we_regf, instr_done and illegal_op to 0, and hold the remaining outputs at their FETCH values.
REQ-032 SHALL, if reset is asserted mid-instruction, abandon that instruction with no further write strobes; the first rising edge after release advances FETCH->DECODE.

Structure
REQ-033 SHALL take the state enum, the opcode constants, the funct constants and the alu_cntrl codes from a shared package mips_pkg.
REQ-034 SHALL place the funct-to-alu_cntrl decode in a sub-module alu_decoder (inputs: alu_op[1:0], funct; output: alu_cntrl).

Verification
REQ-035 SHALL cover lw (opcode 100011): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; we_regf=1 and mem_to_reg=1 only in cycle 5; instr_done in cycle 5.
REQ-036 SHALL cover sw (101011): mem_write=1 and iord=1 in cycle 4 only; we_regf never asserted.
REQ-037 SHALL cover beq (000100) with zero_f=1 and then with zero_f=0: pc_en=1 and pc_src=01 in cycle 3 for the taken case; pc_en=0 in cycle 3 for the not-taken case.
REQ-038 SHALL cover R-type with funct 101010, then 100010, then 111111: alu_cntrl=111, 110 and 010 respectively in EXECUTE; ALUWB has reg_dst=1.
REQ-039 SHALL cover opcode 111111: illegal_op=1 and instr_done=1 in cycle 2, and the next state is FETCH.
REQ-040 SHALL cover rst driven low in MEMRD: the state is FETCH immediately and all write strobes are 0; after release, the next edge gives DECODE.
